clk_div_rst_gen: RTL and testbench

CLK_DIV_RST_GEN -- requirements
Module: clk_div_rst_gen

---
 rtl/eth_clk_pkg.sv | 8 +
 rtl/clk_div_ch.sv | 105 ++++++++++
 rtl/clk_div_rst_gen.sv | 47 ++++
 tb/tb_clk_div_rst_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_clk_pkg.sv
// rtl/eth_clk_pkg.sv - shared defaults and types for the divided-clock/reset generator
package eth_clk_pkg;
    localparam int DEF_MDC_DIV  = 50;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_RST_HOLD = 4;

    typedef logic [DEF_DIV_W-1:0] div_t;
endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divided-clock channel: half-period counter, divisor registers, strobes, reset hold
module clk_div_ch #(
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = 50,
    parameter int RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] cfg,
    input  logic             load,
    input  logic             en,
    output logic             div_clk,
    output logic             div_rise,
    output logic             div_fall,
    output logic             div_rst
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'((DEF_DIV < 1) ? 1 : DEF_DIV);

    logic [DIV_W-1:0]  cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
    logic [DIV_W-1:0]  cfg_eff;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              on_q, on_d, clk_q, clk_d, rise_q, rise_d, fall_q, fall_d, rst_q, rst_d;
    logic              boundary;

    always_comb begin
        cfg_eff  = (cfg == '0) ? DIV_W'(1) : cfg;
        boundary = (cnt_q == act_q - DIV_W'(1));
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        on_d     = on_q;
        clk_d    = clk_q;
        hold_d   = hold_q;
        rst_d    = rst_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (!run) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            on_d   = 1'b0;
            hold_d = '0;
            rst_d  = 1'b1;
        end else begin
            // A stopped channel has no phase to protect, so a load takes effect at once.
            if (load) begin
                pend_d = cfg_eff;
                if (!clk_q && !en) act_d = cfg_eff;
            end
            if (!on_q) begin
                if (en) begin
                    on_d  = 1'b1;
                    clk_d = 1'b1;
                    cnt_d = '0;
                end
            end else if (!clk_q && !en) begin
                on_d  = 1'b0;
                cnt_d = '0;
            end else if (boundary) begin
                cnt_d = '0;
                clk_d = ~clk_q;
                act_d = pend_q;
                if (clk_q && !en) on_d = 1'b0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            rise_d = clk_d & ~clk_q;
            fall_d = ~clk_d & clk_q;
            if (rise_q && rst_q) begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) rst_d = 1'b0;
                else                                 hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DEF_VAL;
            pend_q <= DEF_VAL;
            hold_q <= '0;
            on_q   <= 1'b0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            rst_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            hold_q <= hold_d;
            on_q   <= on_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            rst_q  <= rst_d;
        end
    end

    assign div_clk  = clk_q;
    assign div_rise = rise_q;
    assign div_fall = fall_q;
    assign div_rst  = rst_q;
endmodule

// File: rtl/clk_div_rst_gen.sv
// rtl/clk_div_rst_gen.sv - reset release synchronizer and per-channel divided-clock generators
module clk_div_rst_gen
    import eth_clk_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int DEF_DIV  = DEF_MDC_DIV,
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic                    Clk,
    input  logic                    Rstn,
    input  logic [NUM_CH*DIV_W-1:0] Div_Cfg,
    input  logic [NUM_CH-1:0]       Div_Load,
    input  logic [NUM_CH-1:0]       Ch_En,
    output logic [NUM_CH-1:0]       Div_Clk,
    output logic [NUM_CH-1:0]       Div_Rise,
    output logic [NUM_CH-1:0]       Div_Fall,
    output logic [NUM_CH-1:0]       Div_Rst
);
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], 1'b1};

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .RST_HOLD(RST_HOLD)
        ) u_ch (
            .clk     (Clk),
            .rst_n   (Rstn),
            .run     (sync_q[1]),
            .cfg     (Div_Cfg[g*DIV_W +: DIV_W]),
            .load    (Div_Load[g]),
            .en      (Ch_En[g]),
            .div_clk (Div_Clk[g]),
            .div_rise(Div_Rise[g]),
            .div_fall(Div_Fall[g]),
            .div_rst (Div_Rst[g])
        );
    end
endmodule

// File: tb/tb_clk_div_rst_gen.sv
// tb/tb_clk_div_rst_gen.sv - scoreboard bench for clk_div_rst_gen phase lengths, strobes and reset hold
module tb_clk_div_rst_gen;
    localparam int NCH = 2;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH*DW-1:0] div_cfg;
    logic [NCH-1:0]    div_load, ch_en;
    logic [NCH-1:0]    div_clk, div_rise, div_fall, div_rst;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];
    logic prev[NCH];
    int   len[NCH];

    clk_div_rst_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(50), .RST_HOLD(4)) dut (
        .Clk     (clk),
        .Rstn    (rstn),
        .Div_Cfg (div_cfg),
        .Div_Load(div_load),
        .Ch_En   (ch_en),
        .Div_Clk (div_clk),
        .Div_Rise(div_rise),
        .Div_Fall(div_fall),
        .Div_Rst (div_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qpop(input int c);
        if (c == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic push(input int c, input int v);
        if (c == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Each level change closes a phase; its length is checked against the next queued expectation.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!rstn) begin
                prev[c] = 1'b0;
                len[c]  = 0;
            end else begin
                chk($sformatf("rise_strobe_ch%0d", c), int'(div_rise[c]), int'(div_clk[c] & ~prev[c]));
                chk($sformatf("fall_strobe_ch%0d", c), int'(div_fall[c]), int'(~div_clk[c] & prev[c]));
                if (div_clk[c] != prev[c]) begin
                    if (qsize(c) > 0) chk($sformatf("phase_len_ch%0d", c), len[c], qpop(c));
                    len[c] = 1;
                end else begin
                    len[c]++;
                end
                prev[c] = div_clk[c];
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ev(input int c, input bit rise, input int budget, output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            found = rise ? div_rise[c] : div_fall[c];
        end
        #1;
        if (!found) chk("wait_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() + q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_done", q0.size() + q1.size(), 0);
    endtask

    // Entered right after the first rise following release.
    task automatic rst_hold_check();
        int rises = 1;
        int cycles = 0;
        int early = 0;
        while (rises < 4 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (div_rise[0]) rises++;
            if (!div_rst[0]) early++;
        end
        chk("rst_hold_rises", rises, 4);
        chk("rst_early_release", early, 0);
        chk("rst_at_rise4_ch0", int'(div_rst[0]), 1);
        chk("rst_at_rise4_ch1", int'(div_rst[1]), 1);
        @(negedge clk);
        chk("rst_released_ch0", int'(div_rst[0]), 0);
        chk("rst_released_ch1", int'(div_rst[1]), 0);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        rstn     = 1'b0;
        div_cfg  = {8'd50, 8'd50};
        div_load = '0;
        ch_en    = '0;
        cyc(3);
        chk("reset_div_clk", int'(div_clk), 0);
        chk("reset_rise", int'(div_rise), 0);
        chk("reset_fall", int'(div_fall), 0);
        chk("reset_div_rst", int'(div_rst), 3);

        // Default divisor, both channels enabled through release.
        ch_en = 2'b11;
        cyc(1);
        rstn = 1'b1;
        wait_ev(0, 1'b1, 10, n);
        chk("first_rise_latency", n, 3);
        chk("ch1_first_rise", int'(div_rise[1]), 1);
        for (int i = 0; i < 6; i++) begin
            push(0, 50);
            push(1, 50);
        end
        rst_hold_check();

        // Load 25 on ch0 at count 10 of a high phase.
        wait_ev(0, 1'b1, 200, n);
        push(0, 50);
        for (int i = 0; i < 4; i++) push(0, 25);
        for (int i = 0; i < 3; i++) push(1, 50);
        cyc(10);
        div_cfg[7:0] = 8'd25;
        div_load     = 2'b01;
        cyc(1);
        div_load = '0;
        drain(400);

        // Load coincident with a boundary: old pending for one more phase.
        wait_ev(0, 1'b1, 100, n);
        push(0, 25);
        push(0, 25);
        push(0, 10);
        push(0, 10);
        cyc(24);
        div_cfg[7:0] = 8'd10;
        div_load     = 2'b01;
        cyc(1);
        div_load = '0;
        wait_ev(0, 1'b1, 100, n);
        wait_ev(0, 1'b0, 100, n);
        wait_ev(0, 1'b1, 100, n);
        chk("boundary_load_drained", q0.size(), 0);

        // Back to 50 mid-phase, then drop enable at count 5 of a high phase.
        push(0, 10);
        push(0, 50);
        push(0, 50);
        div_cfg[7:0] = 8'd50;
        div_load     = 2'b01;
        cyc(1);
        div_load = '0;
        wait_ev(0, 1'b0, 100, n);
        wait_ev(0, 1'b1, 100, n);
        cyc(5);
        ch_en[0] = 1'b0;
        wait_ev(0, 1'b0, 100, n);
        chk("en_drop_fall_delay", n, 45);
        chk("en_drop_drained", q0.size(), 0);
        bad = 0;
        repeat (120) begin
            @(negedge clk);
            if (div_clk[0] || div_rise[0] || div_fall[0]) bad++;
        end
        #1;
        chk("stopped_quiet", bad, 0);
        chk("stopped_rst_low", int'(div_rst[0]), 0);

        // Load 0 while stopped: immediate, period 2.
        div_cfg[7:0] = 8'd0;
        div_load     = 2'b01;
        cyc(1);
        div_load = '0;
        ch_en[0] = 1'b1;
        @(negedge clk);
        chk("en_start_rise", int'(div_rise[0]), 1);
        #1;
        for (int i = 0; i < 6; i++) push(0, 1);
        drain(50);

        // Drop enable while low: stops at once.
        n = 0;
        while (div_clk[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("found_low_phase", int'(div_clk[0]), 0);
        ch_en[0] = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (div_clk[0] || div_rise[0] || div_fall[0]) bad++;
        end
        #1;
        chk("stop_low_quiet", bad, 0);
        div_cfg[7:0] = 8'd50;
        div_load     = 2'b01;
        cyc(1);
        div_load = '0;
        ch_en[0] = 1'b1;
        wait_ev(0, 1'b1, 5, n);
        chk("restart_latency", n, 1);
        push(0, 50);
        push(0, 50);
        drain(150);

        // Asynchronous reset mid-phase.
        cyc(7);
        rstn = 1'b0;
        #1;
        chk("async_rst_div_clk", int'(div_clk), 0);
        chk("async_rst_div_rst", int'(div_rst), 3);
        chk("async_rst_strobes", int'(div_rise | div_fall), 0);
        cyc(2);
        rstn = 1'b1;
        wait_ev(0, 1'b1, 10, n);
        chk("rerelease_first_rise", n, 3);
        push(0, 50);
        push(0, 50);
        rst_hold_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
